instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Consumes assembled 32-bit words from the UART word-assembly stage (`word_valid` pulse plus `word_in`).
- Writes each word sequentially into MIPS instruction memory, starting at word address 0.
- Detects an end-of-program marker word, then releases the processor via `mips_enable`.
- Sits between the receive interface and the instruction-memory write port.
- Owns the boot/load sequence: no CPU execution until a complete program has been loaded.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity = 2^ADDR_W words.
- EOP_WORD, 32'hFFFF_FFFF, end-of-program marker; it is never written to memory.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- word_in  input  32  assembled word; valid only while `word_valid` = 1.
- word_valid  input  1  one-cycle pulse per assembled word; back-to-back pulses are legal.
- restart  input  1  one-cycle pulse that abandons the current or finished load and re-arms.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse.
- mem_addr  output  ADDR_W  instruction-memory word address.
- mem_wdata  output  32  instruction-memory write data.
- mips_enable  output  1  level; 1 = processor may run.
- load_busy  output  1  level; 1 while in LOAD.
- load_done  output  1  level; 1 while in DONE.
- overflow  output  1  sticky error flag.
- word_count  output  ADDR_W+1  number of words written in the current load.

Behaviour:
- Reset values: state = IDLE; mem_we = 0, mem_addr = 0, mem_wdata = 0, mips_enable = 0, load_busy = 0, load_done = 0, overflow = 0, word_count = 0; internal write pointer = 0.
- Reset does not clear memory contents.
- All outputs are registered. Latency from a `word_valid` cycle N to the corresponding `mem_we` is exactly 1 cycle (asserted in N+1). `mem_addr` and `mem_wdata` are valid in that same cycle.
- `mem_we` is high for exactly one cycle per accepted word. `mem_addr` and `mem_wdata` hold their last values when `mem_we` = 0.
- There is no backpressure; every `word_valid` pulse is acted on in the cycle it occurs.
- States:
  - IDLE: waiting for the first word.
    - `word_valid` with `word_in` != EOP_WORD → write at pointer 0, pointer ← 1, word_count ← 1, go to LOAD.
    - `word_valid` with `word_in` == EOP_WORD → empty program: go to DONE, word_count = 0, no write.
  - LOAD: `load_busy` = 1.
    - `word_valid` with `word_in` != EOP_WORD and pointer < 2^ADDR_W → write at pointer, then pointer +1 and word_count +1.
    - `word_valid` with `word_in` == EOP_WORD → go to DONE, no write.
    - `word_valid` with `word_in` != EOP_WORD and pointer == 2^ADDR_W (memory full) → go to ERROR, no write.
  - DONE: `load_done` = 1 and `mips_enable` = 1. Both assert in the cycle after the EOP pulse. `word_valid` is ignored (no write, no state change).
  - ERROR: `overflow` = 1 and `mips_enable` = 0. `word_valid` is ignored.
- Pointer is ADDR_W+1 bits internally; `mem_addr` = pointer[ADDR_W-1:0]. The pointer never wraps: exactly 2^ADDR_W words fit, and the next non-EOP word is an overflow. EOP arriving when the memory is full is legal and goes to DONE.
- `restart` from any state, with effect in the next cycle:
  - state ← IDLE; pointer, word_count, `overflow`, `mips_enable`, `load_done`, `load_busy` all cleared; `mem_we` = 0.
  - If `restart` and `word_valid` coincide, `restart` wins and the word is dropped.
- Reset mid-load: same effect as `restart`. A partial program remains in memory but `mips_enable` stays 0.
- Synchronous reset has priority over `restart` and `word_valid`.

Test Plan:
- Reset, then `word_valid` with 32'h2001_0005, 32'h2002_0003, 32'hFFFF_FFFF on separate cycles → writes (addr 0, 32'h2001_0005) and (addr 1, 32'h2002_0003), each one cycle after its pulse. `mips_enable` = 1, `load_done` = 1 and `word_count` = 2 one cycle after EOP; no write for the EOP word.
- Five back-to-back `word_valid` pulses (1, 2, 3, 4, EOP) → four consecutive `mem_we` cycles at addr 0–3 with data 1–4. DONE is entered the cycle after EOP with `word_count` = 4.
- ADDR_W = 2: four data words then a fifth non-EOP word → `overflow` = 1, `mips_enable` = 0, only 4 writes. A second run of four words then EOP → DONE with `word_count` = 4.
- First word is EOP → DONE, `word_count` = 0, `mips_enable` = 1, zero writes. A further `word_valid` with 32'h1234_5678 → no write.
- In DONE, `restart` pulsed together with `word_valid` (32'hAAAA_AAAA) → next cycle IDLE with `mips_enable` = 0 and no write. A new word 32'h5555_5555 → written at addr 0.
- Reset asserted in LOAD after 3 words → all outputs at reset values the next cycle. A subsequent load restarts at addr 0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot loader: streams assembled UART words into instruction memory
// and releases the CPU once the end-of-program marker arrives.
module instr_mem_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] EOP_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mips_enable,
    output logic              load_busy,
    output logic              load_done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    logic [ADDR_W:0] ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            word_count  <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mips_enable <= 1'b0;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                state       <= IDLE;
                ptr         <= '0;
                word_count  <= '0;
                mips_enable <= 1'b0;
                load_busy   <= 1'b0;
                load_done   <= 1'b0;
                overflow    <= 1'b0;
            end else if (word_valid) begin
                case (state)
                    IDLE, LOAD: begin
                        if (word_in == EOP_WORD) begin
                            state       <= DONE;
                            load_busy   <= 1'b0;
                            load_done   <= 1'b1;
                            mips_enable <= 1'b1;
                        end else if (ptr < CAP) begin
                            state      <= LOAD;
                            load_busy  <= 1'b1;
                            mem_we     <= 1'b1;
                            mem_addr   <= ptr[ADDR_W-1:0];
                            mem_wdata  <= word_in;
                            ptr        <= ptr + 1'b1;
                            word_count <= ptr + 1'b1;
                        end else begin
                            // Memory full: refuse the word rather than wrap.
                            state     <= ERROR;
                            load_busy <= 1'b0;
                            overflow  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: write scoreboard plus status checks on a
// full-size instance and a 4-word instance for the overflow path.
module tb_instr_mem_loader;

    localparam logic [31:0] EOP = 32'hFFFF_FFFF;
    localparam int S_IDLE = 0, S_LOAD = 1, S_DONE = 2, S_ERR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] a_word = '0;
    logic        a_valid = 1'b0, a_restart = 1'b0;
    logic        a_we, a_en, a_busy, a_done, a_ovf;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [10:0] a_cnt;

    logic [31:0] b_word = '0;
    logic        b_valid = 1'b0, b_restart = 1'b0;
    logic        b_we, b_en, b_busy, b_done, b_ovf;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_cnt;

    instr_mem_loader u_dut (
        .clk(clk), .reset(reset), .word_in(a_word),
        .word_valid(a_valid), .restart(a_restart),
        .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mips_enable(a_en), .load_busy(a_busy), .load_done(a_done),
        .overflow(a_ovf), .word_count(a_cnt)
    );

    instr_mem_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .reset(reset), .word_in(b_word),
        .word_valid(b_valid), .restart(b_restart),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mips_enable(b_en), .load_busy(b_busy), .load_done(b_done),
        .overflow(b_ovf), .word_count(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;
    int  cyc = 0;
    int  n_chk = 0, n_pass = 0;
    int  m_st[2], m_ptr[2];
    int  cap[2] = '{1024, 4};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (a_we) begin
            if (q0.size() == 0) check("a.unexp_wr", 64'(a_addr), 64'hDEAD);
            else begin
                e0 = q0.pop_front();
                check("a.addr", 64'(a_addr), 64'(e0.addr));
                check("a.data", 64'(a_wdata), 64'(e0.data));
                check("a.lat", 64'(cyc), 64'(e0.cyc));
            end
        end
        if (b_we) begin
            if (q1.size() == 0) check("b.unexp_wr", 64'(b_addr), 64'hDEAD);
            else begin
                e1 = q1.pop_front();
                check("b.addr", 64'(b_addr), 64'(e1.addr));
                check("b.data", 64'(b_wdata), 64'(e1.data));
                check("b.lat", 64'(cyc), 64'(e1.cyc));
            end
        end
    end

    task automatic clr_in();
        a_valid = 1'b0; a_restart = 1'b0;
        b_valid = 1'b0; b_restart = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        clr_in();
    endtask

    task automatic send(input int d, input logic [31:0] w);
        wr_t e;
        @(negedge clk);
        clr_in();
        if (d == 0) begin a_valid = 1'b1; a_word = w; end
        else begin b_valid = 1'b1; b_word = w; end
        if (m_st[d] == S_IDLE || m_st[d] == S_LOAD) begin
            if (w == EOP) m_st[d] = S_DONE;
            else if (m_ptr[d] < cap[d]) begin
                e.addr = m_ptr[d]; e.data = w; e.cyc = cyc + 1;
                if (d == 0) q0.push_back(e); else q1.push_back(e);
                m_ptr[d]++;
                m_st[d] = S_LOAD;
            end else m_st[d] = S_ERR;
        end
    endtask

    task automatic rst_pulse(input int d, input logic v, input logic [31:0] w);
        @(negedge clk);
        clr_in();
        if (d == 0) begin a_restart = 1'b1; a_valid = v; a_word = w; end
        else begin b_restart = 1'b1; b_valid = v; b_word = w; end
        m_st[d] = S_IDLE;
        m_ptr[d] = 0;
    endtask

    task automatic chk_out(input int d, input string tag);
        logic en, bz, dn, ov;
        int   wc;
        if (d == 0) begin
            en = a_en; bz = a_busy; dn = a_done; ov = a_ovf; wc = int'(a_cnt);
        end else begin
            en = b_en; bz = b_busy; dn = b_done; ov = b_ovf; wc = int'(b_cnt);
        end
        check({tag, ".en"}, 64'(en), 64'(m_st[d] == S_DONE));
        check({tag, ".busy"}, 64'(bz), 64'(m_st[d] == S_LOAD));
        check({tag, ".done"}, 64'(dn), 64'(m_st[d] == S_DONE));
        check({tag, ".ovf"}, 64'(ov), 64'(m_st[d] == S_ERR));
        check({tag, ".cnt"}, 64'(wc), 64'(m_ptr[d]));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".we"}, 64'(a_we), 64'd0);
        check({tag, ".addr"}, 64'(a_addr), 64'd0);
        check({tag, ".wdata"}, 64'(a_wdata), 64'd0);
        chk_out(0, tag);
        chk_out(1, {tag, "_s"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_in();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin m_st[d] = S_IDLE; m_ptr[d] = 0; end
        @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin m_st[d] = S_IDLE; m_ptr[d] = 0; end
        repeat (3) @(negedge clk);
        chk_reset("por");
        reset = 1'b0;

        send(0, 32'h2001_0005); idle();
        send(0, 32'h2002_0003); idle();
        send(0, EOP); idle();
        chk_out(0, "prog3");

        rst_pulse(0, 1'b0, '0); idle();
        chk_out(0, "rs1");
        for (int i = 1; i <= 4; i++) send(0, 32'(i));
        send(0, EOP); idle();
        chk_out(0, "b2b");

        rst_pulse(0, 1'b0, '0);
        send(0, EOP); idle();
        chk_out(0, "empty");
        send(0, 32'h1234_5678); idle();
        chk_out(0, "done_ign");

        rst_pulse(0, 1'b1, 32'hAAAA_AAAA); idle();
        chk_out(0, "rs_drop");
        send(0, 32'h5555_5555); idle();
        chk_out(0, "after_rs");

        send(0, 32'h0000_0011);
        send(0, 32'h0000_0022);
        do_reset();
        send(0, 32'h0000_0077); idle();
        send(0, EOP); idle();
        chk_out(0, "reload");

        for (int i = 0; i < 4; i++) send(1, 32'h100 + 32'(i));
        idle();
        chk_out(1, "full");
        send(1, 32'h0000_0BAD); idle();
        chk_out(1, "ovf");
        send(1, 32'h0000_0C0D); idle();
        chk_out(1, "err_ign");
        rst_pulse(1, 1'b0, '0);
        for (int i = 0; i < 4; i++) send(1, 32'h200 + 32'(i));
        send(1, EOP); idle();
        chk_out(1, "full_eop");

        repeat (3) idle();
        check("a.sb_empty", 64'(q0.size()), 64'd0);
        check("b.sb_empty", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
